// File: rtl/reservation_station.sv
// Single-entry Tomasulo reservation station: captures renamed operands, snoops the CDB,
// dispatches to its FU and broadcasts the result under RS_ID. Optional flush: RS_FLUSH_EN.
package reservation_station_pkg;
  typedef enum logic [2:0] {
    FU_ALU0 = 3'd0,
    FU_ALU1 = 3'd1,
    FU_MUL  = 3'd2,
    FU_DIV  = 3'd3,
    FU_LSU  = 3'd4
  } e_functional_unit;
endpackage

// Operand port layout: bit DATA_WIDTH is is_virtual; the low bits carry data.value,
// or data.rs_id in the low $bits(e_functional_unit) bits when virtual.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int               DATA_WIDTH = 64,
  parameter int               OP_WIDTH   = 4,
  parameter e_functional_unit RS_ID      = FU_ALU0
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef RS_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [OP_WIDTH-1:0]   issue_op_i,
  input  logic [DATA_WIDTH:0]   issue_src1_i,
  input  logic [DATA_WIDTH:0]   issue_src2_i,
  input  logic                  bcast_valid_i,
  input  logic [DATA_WIDTH-1:0] bcast_value_i,
  input  e_functional_unit      bcast_rs_i,
  output logic                  fu_valid_o,
  input  logic                  fu_ready_i,
  output logic [OP_WIDTH-1:0]   fu_op_o,
  output logic [DATA_WIDTH-1:0] fu_a_o,
  output logic [DATA_WIDTH-1:0] fu_b_o,
  input  logic                  fu_done_i,
  input  logic [DATA_WIDTH-1:0] fu_result_i,
  output logic                  cdb_req_o,
  input  logic                  cdb_grant_i,
  output logic [DATA_WIDTH-1:0] cdb_value_o,
  output e_functional_unit      cdb_rs_o,
  output logic                  busy_o
);
  localparam int TW = $bits(e_functional_unit);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_OPS, S_DISPATCH, S_EXEC, S_BROADCAST
  } state_e;

  state_e                state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic                  a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  e_functional_unit      a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  e_functional_unit      src1_tag, src2_tag;
  logic                  flush_w;

`ifdef RS_FLUSH_EN
  assign flush_w = flush_i;
`else
  assign flush_w = 1'b0;
`endif

  assign src1_tag = e_functional_unit'(issue_src1_i[TW-1:0]);
  assign src2_tag = e_functional_unit'(issue_src2_i[TW-1:0]);

  // Our own broadcasts never feed our own operands.
  function automatic logic hit(input e_functional_unit tag);
    return bcast_valid_i && (bcast_rs_i == tag) && (bcast_rs_i != RS_ID);
  endfunction

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    a_rdy_d       = a_rdy_q;
    b_rdy_d       = b_rdy_q;
    a_tag_d       = a_tag_q;
    b_tag_d       = b_tag_q;
    res_d         = res_q;
    issue_ready_o = 1'b0;
    fu_valid_o    = 1'b0;
    cdb_req_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        issue_ready_o = 1'b1;
        if (issue_valid_i) begin
          op_d = issue_op_i;
          if (!issue_src1_i[DATA_WIDTH]) begin
            a_d     = issue_src1_i[DATA_WIDTH-1:0];
            a_rdy_d = 1'b1;
          end else begin
            a_tag_d = src1_tag;
            a_rdy_d = hit(src1_tag);
            if (hit(src1_tag)) a_d = bcast_value_i;
          end
          if (!issue_src2_i[DATA_WIDTH]) begin
            b_d     = issue_src2_i[DATA_WIDTH-1:0];
            b_rdy_d = 1'b1;
          end else begin
            b_tag_d = src2_tag;
            b_rdy_d = hit(src2_tag);
            if (hit(src2_tag)) b_d = bcast_value_i;
          end
          state_d = (a_rdy_d && b_rdy_d) ? S_DISPATCH : S_WAIT_OPS;
        end
      end
      S_WAIT_OPS: begin
        if (!a_rdy_q && hit(a_tag_q)) begin
          a_d     = bcast_value_i;
          a_rdy_d = 1'b1;
        end
        if (!b_rdy_q && hit(b_tag_q)) begin
          b_d     = bcast_value_i;
          b_rdy_d = 1'b1;
        end
        if (a_rdy_d && b_rdy_d) state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        fu_valid_o = 1'b1;
        if (fu_ready_i) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (fu_done_i) begin
          res_d   = fu_result_i;
          state_d = S_BROADCAST;
        end
      end
      S_BROADCAST: begin
        cdb_req_o = 1'b1;
        if (cdb_grant_i) begin
          state_d = S_IDLE;
          a_rdy_d = 1'b0;
          b_rdy_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything this cycle, including a same-cycle issue.
    if (flush_w) begin
      state_d = S_IDLE;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      a_tag_d = a_tag_q;
      b_tag_d = b_tag_q;
      res_d   = res_q;
      a_rdy_d = 1'b0;
      b_rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      a_rdy_q <= 1'b0;
      b_rdy_q <= 1'b0;
      a_tag_q <= FU_ALU0;
      b_tag_q <= FU_ALU0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      a_rdy_q <= a_rdy_d;
      b_rdy_q <= b_rdy_d;
      a_tag_q <= a_tag_d;
      b_tag_q <= b_tag_d;
    end
  end

  assign fu_op_o     = op_q;
  assign fu_a_o      = a_q;
  assign fu_b_o      = b_q;
  assign cdb_value_o = res_q;
  assign cdb_rs_o    = RS_ID;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int DW = 64;
  localparam int OW = 4;
  localparam e_functional_unit MY_ID = FU_MUL;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic issue_valid, issue_ready;
  logic [OW-1:0] issue_op;
  logic [DW:0] src1, src2;
  logic bcast_valid;
  logic [DW-1:0] bcast_value;
  e_functional_unit bcast_rs;
  logic fu_valid, fu_ready, fu_done;
  logic [OW-1:0] fu_op;
  logic [DW-1:0] fu_a, fu_b, fu_result, cdb_value;
  logic cdb_req, cdb_grant, busy;
  e_functional_unit cdb_rs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reservation_station #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .RS_ID(MY_ID)) dut (
    .clk(clk), .rst(rst),
`ifdef RS_FLUSH_EN
    .flush_i(flush),
`endif
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_op_i(issue_op),
    .issue_src1_i(src1), .issue_src2_i(src2),
    .bcast_valid_i(bcast_valid), .bcast_value_i(bcast_value), .bcast_rs_i(bcast_rs),
    .fu_valid_o(fu_valid), .fu_ready_i(fu_ready), .fu_op_o(fu_op),
    .fu_a_o(fu_a), .fu_b_o(fu_b), .fu_done_i(fu_done), .fu_result_i(fu_result),
    .cdb_req_o(cdb_req), .cdb_grant_i(cdb_grant), .cdb_value_o(cdb_value),
    .cdb_rs_o(cdb_rs), .busy_o(busy)
  );

  // Transaction-level model: where the single entry is in its life, plus its payload.
  typedef enum int {P_FREE, P_WAITING, P_OFFERED, P_RUNNING, P_RESULT} phase_e;
  phase_e           m_ph;
  logic [OW-1:0]    m_op;
  logic [DW-1:0]    m_val [2];
  logic             m_rdy [2];
  e_functional_unit m_tag [2];
  logic [DW-1:0]    m_res;

  function automatic logic [DW:0] mk(input logic virt, input logic [DW-1:0] v,
                                     input e_functional_unit t);
    return virt ? {1'b1, {(DW-3){1'b0}}, t} : {1'b0, v};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("issue_ready", DW'(issue_ready), DW'(m_ph == P_FREE));
    chk("busy", DW'(busy), DW'(m_ph != P_FREE));
    chk("fu_valid", DW'(fu_valid), DW'(m_ph == P_OFFERED));
    chk("cdb_req", DW'(cdb_req), DW'(m_ph == P_RESULT));
    chk("cdb_rs", DW'(cdb_rs), DW'(MY_ID));
    if (m_ph == P_OFFERED) begin
      chk("fu_op", DW'(fu_op), DW'(m_op));
      chk("fu_a", fu_a, m_val[0]);
      chk("fu_b", fu_b, m_val[1]);
    end
    if (m_ph == P_RESULT) chk("cdb_value", cdb_value, m_res);
  endtask

  function automatic logic snoops(input e_functional_unit t);
    return bcast_valid && bcast_rs == t && t != MY_ID;
  endfunction

  task automatic model_reset();
    m_ph = P_FREE; m_op = '0; m_res = '0;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = '0; m_rdy[i] = 1'b0; m_tag[i] = FU_ALU0;
    end
  endtask

  task automatic model_advance();
    logic [DW:0] s [2];
    s[0] = src1; s[1] = src2;
    if (rst) begin
      model_reset();
    end else if (flush === 1'b1) begin
      m_ph = P_FREE; m_rdy[0] = 1'b0; m_rdy[1] = 1'b0;
    end else begin
      case (m_ph)
        P_FREE: if (issue_valid) begin
          m_op = issue_op;
          for (int i = 0; i < 2; i++) begin
            if (!s[i][DW]) begin
              m_val[i] = s[i][DW-1:0]; m_rdy[i] = 1'b1;
            end else begin
              m_tag[i] = e_functional_unit'(s[i][2:0]);
              m_rdy[i] = snoops(m_tag[i]);
              if (m_rdy[i]) m_val[i] = bcast_value;
            end
          end
          m_ph = (m_rdy[0] && m_rdy[1]) ? P_OFFERED : P_WAITING;
        end
        P_WAITING: begin
          for (int i = 0; i < 2; i++)
            if (!m_rdy[i] && snoops(m_tag[i])) begin
              m_val[i] = bcast_value; m_rdy[i] = 1'b1;
            end
          if (m_rdy[0] && m_rdy[1]) m_ph = P_OFFERED;
        end
        P_OFFERED: if (fu_ready) m_ph = P_RUNNING;
        P_RUNNING: if (fu_done) begin m_res = fu_result; m_ph = P_RESULT; end
        P_RESULT: if (cdb_grant) begin
          m_ph = P_FREE; m_rdy[0] = 1'b0; m_rdy[1] = 1'b0;
        end
        default: m_ph = P_FREE;
      endcase
    end
  endtask

  // Called just after a rising edge: check outputs mid-cycle, advance model, clock.
  task automatic step();
    @(negedge clk);
    model_check();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; bcast_valid = 0; fu_ready = 0; fu_done = 0; cdb_grant = 0;
    flush = 0; rst = 0;
  endtask

  task automatic issue(input logic v1, input logic [DW-1:0] d1, input e_functional_unit t1,
                       input logic v2, input logic [DW-1:0] d2, input e_functional_unit t2,
                       input logic [OW-1:0] op);
    issue_valid = 1; issue_op = op;
    src1 = mk(v1, d1, t1); src2 = mk(v2, d2, t2);
    step();
    issue_valid = 0;
  endtask

  task automatic bcast(input e_functional_unit t, input logic [DW-1:0] v);
    bcast_valid = 1; bcast_rs = t; bcast_value = v;
    step();
    bcast_valid = 0;
  endtask

  task automatic finish_txn(input logic [DW-1:0] r);
    fu_ready = 1; step(); fu_ready = 0;
    fu_done = 1; fu_result = r; step(); fu_done = 0;
    cdb_grant = 1; step(); cdb_grant = 0;
  endtask

  initial begin
    idle_inputs();
    issue_op = '0; src1 = '0; src2 = '0; bcast_value = '0; bcast_rs = FU_ALU0;
    fu_result = '0;
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    rst = 0;
    chk("rst_issue_ready", DW'(issue_ready), 1);
    chk("rst_fu_valid", DW'(fu_valid), 0);
    chk("rst_cdb_req", DW'(cdb_req), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_fu_a", fu_a, 0);
    chk("rst_fu_b", fu_b, 0);
    chk("rst_cdb_value", cdb_value, 0);

    // Ready issue end to end.
    issue(0, 5, FU_ALU0, 0, 7, FU_ALU0, 4'd3);
    chk("ready_fu_valid", DW'(fu_valid), 1);
    chk("ready_a", fu_a, 5);
    chk("ready_b", fu_b, 7);
    chk("ready_op", DW'(fu_op), 3);
    fu_ready = 1; step(); fu_ready = 0;
    chk("exec_fu_valid", DW'(fu_valid), 0);
    fu_done = 1; fu_result = 12; step(); fu_done = 0;
    chk("bc_req", DW'(cdb_req), 1);
    chk("bc_value", cdb_value, 12);
    chk("bc_rs", DW'(cdb_rs), DW'(FU_MUL));
    cdb_grant = 1; step(); cdb_grant = 0;
    chk("grant_issue_ready", DW'(issue_ready), 1);

    // Wait on two tags, unrelated tag ignored.
    issue(1, 0, FU_ALU0, 1, 0, FU_ALU1, 4'd1);
    bcast(FU_DIV, 64'hDEAD);
    bcast(FU_ALU1, 9);
    step();
    chk("wait_no_valid", DW'(fu_valid), 0);
    bcast(FU_ALU0, 4);
    chk("wait_fu_valid", DW'(fu_valid), 1);
    chk("wait_a", fu_a, 4);
    chk("wait_b", fu_b, 9);
    finish_txn(64'h1234);

    // Same-cycle bypass.
    bcast_valid = 1; bcast_rs = FU_ALU0; bcast_value = 64'h55;
    issue(1, 0, FU_ALU0, 0, 1, FU_ALU0, 4'd2);
    bcast_valid = 0;
    chk("bypass_fu_valid", DW'(fu_valid), 1);
    chk("bypass_a", fu_a, 64'h55);
    chk("bypass_b", fu_b, 1);
    finish_txn(64'h77);

    // Dual capture from one broadcast.
    issue(1, 0, FU_ALU0, 1, 0, FU_ALU0, 4'd5);
    bcast(FU_ALU0, '1);
    chk("dual_a", fu_a, '1);
    chk("dual_b", fu_b, '1);
    finish_txn(64'h0);

    // Backpressure on FU and CDB; issue refused throughout including grant cycle.
    issue(0, 64'h11, FU_ALU0, 0, 64'h22, FU_ALU0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_fu_valid", DW'(fu_valid), 1);
      chk("bp_a", fu_a, 64'h11);
    end
    fu_ready = 1; step(); fu_ready = 0;
    fu_done = 1; fu_result = 64'h99; step(); fu_done = 0;
    issue_valid = 1; src1 = mk(0, 1, FU_ALU0); src2 = mk(0, 2, FU_ALU0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_cdb_req", DW'(cdb_req), 1);
      chk("bp_cdb_value", cdb_value, 64'h99);
      chk("bp_issue_ready", DW'(issue_ready), 0);
    end
    cdb_grant = 1; step(); cdb_grant = 0; issue_valid = 0;
    chk("grant_no_issue", DW'(busy), 0);

    // Own tag never captured; reset drops the stuck entry.
    issue(1, 0, FU_MUL, 0, 3, FU_ALU0, 4'd1);
    bcast(FU_MUL, 64'hAB);
    chk("own_tag_no_valid", DW'(fu_valid), 0);
    rst = 1; step(); rst = 0;
    chk("rst_wait_busy", DW'(busy), 0);

    // Reset in broadcast.
    issue(0, 1, FU_ALU0, 0, 2, FU_ALU0, 4'd1);
    fu_ready = 1; step(); fu_ready = 0;
    fu_done = 1; fu_result = 3; step(); fu_done = 0;
    rst = 1; step(); rst = 0;
    chk("rst_bc_busy", DW'(busy), 0);
    chk("rst_bc_req", DW'(cdb_req), 0);
    chk("rst_bc_issue_ready", DW'(issue_ready), 1);

`ifdef RS_FLUSH_EN
    issue(0, 1, FU_ALU0, 0, 2, FU_ALU0, 4'd1);
    fu_ready = 1; step(); fu_ready = 0;
    flush = 1; step(); flush = 0;
    fu_done = 1; fu_result = 5; step(); fu_done = 0;
    chk("flush_no_req", DW'(cdb_req), 0);
    chk("flush_busy", DW'(busy), 0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_op    = OW'($urandom);
      src1 = mk($urandom_range(0, 1) == 1, {$urandom, $urandom},
                e_functional_unit'($urandom_range(0, 4)));
      src2 = mk($urandom_range(0, 1) == 1, {$urandom, $urandom},
                e_functional_unit'($urandom_range(0, 4)));
      bcast_valid = ($urandom_range(0, 9) < 4);
      bcast_rs    = e_functional_unit'($urandom_range(0, 4));
      bcast_value = {$urandom, $urandom};
      fu_ready    = ($urandom_range(0, 1) == 1);
      fu_done     = ($urandom_range(0, 9) < 3);
      fu_result   = {$urandom, $urandom};
      cdb_grant   = ($urandom_range(0, 9) < 4);
      rst         = ($urandom_range(0, 99) == 0);
`ifdef RS_FLUSH_EN
      flush       = ($urandom_range(0, 49) == 0);
`endif
      step();
    end
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
